// File: rtl/smart_home_ctrl_p.sv
// Smart-home supervisor: priority FSM driving one actuator at a time.
// Sensors: front/rear doors, NUM_WIN windows, fire alarm, room temperature.
// Doors are held open for at least DOOR_HOLD cycles; heating/cooling use a
// hysteresis band of HYST LSBs around the entry thresholds.
// Optional feature macro: SH_ALARM_LATCH_EN -- when defined, ALARM is latched
// until the fire sensor has cleared and alarm_ack is seen on the same edge.

package smart_home_ctrl_p_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FDOOR   = 3'd1,
    ST_RDOOR   = 3'd2,
    ST_ALARM   = 3'd3,
    ST_WIN     = 3'd4,
    ST_HEAT    = 3'd5,
    ST_COOL    = 3'd6,
    ST_ILLEGAL = 3'd7
  } state_e;

endpackage

module smart_home_ctrl_p
  import smart_home_ctrl_p_pkg::*;
#(
  parameter int unsigned NUM_WIN   = 4,
  parameter int unsigned TEMP_W    = 7,
  parameter int unsigned HEAT_TH   = 50,
  parameter int unsigned COOL_TH   = 85,
  parameter int unsigned HYST      = 3,
  parameter int unsigned DOOR_HOLD = 4,
  localparam int unsigned WID_W    = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic               SFD,
  input  logic               SRD,
  input  logic [NUM_WIN-1:0] SW,
  input  logic               SFA,
  input  logic [TEMP_W-1:0]  ST,
  input  logic               alarm_ack,
  output logic               fdoor,
  output logic               rdoor,
  output logic               winbuzz,
  output logic               alarmbuzz,
  output logic               heater,
  output logic               cooler,
  output logic [WID_W-1:0]   win_id,
  output logic [2:0]         display
);

  localparam int unsigned HOLD_W = (DOOR_HOLD > 1) ? $clog2(DOOR_HOLD) : 1;

  // Thresholds truncated to the temperature width.
  localparam logic [TEMP_W-1:0] HEAT_LO = TEMP_W'(HEAT_TH);
  localparam logic [TEMP_W-1:0] HEAT_HI = TEMP_W'(HEAT_TH + HYST);
  localparam logic [TEMP_W-1:0] COOL_HI = TEMP_W'(COOL_TH);
  localparam logic [TEMP_W-1:0] COOL_LO = TEMP_W'(COOL_TH - HYST);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(DOOR_HOLD - 1);

  state_e            state_q, state_d;
  state_e            temp_state;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [WID_W-1:0]  win_id_q, win_id_d, win_idx;
  logic              door_hold;
  logic              alarm_hold;
  logic              fdoor_q, rdoor_q, winbuzz_q, alarmbuzz_q, heater_q, cooler_q;

`ifdef SH_ALARM_LATCH_EN
  logic              latch_q;
`else
  logic              unused_alarm_ack;
  assign unused_alarm_ack = alarm_ack;
`endif

  // Lowest-index open window.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (SW[i]) win_idx = WID_W'(i);
    end
  end

  // Temperature rule: stay inside the hysteresis band, otherwise strict entry.
  always_comb begin
    temp_state = ST_IDLE;
    if (state_q == ST_HEAT && ST < HEAT_HI) begin
      temp_state = ST_HEAT;
    end else if (state_q == ST_COOL && ST > COOL_LO) begin
      temp_state = ST_COOL;
    end else if (ST < HEAT_LO) begin
      temp_state = ST_HEAT;
    end else if (ST > COOL_HI) begin
      temp_state = ST_COOL;
    end
  end

  // Next state by fixed priority, with door hold and optional alarm latch.
  always_comb begin
    state_d    = ST_IDLE;
    hold_d     = '0;
    alarm_hold = 1'b0;
`ifdef SH_ALARM_LATCH_EN
    alarm_hold = latch_q && !(!SFA && alarm_ack);
`endif
    door_hold  = (state_q == ST_FDOOR || state_q == ST_RDOOR) && (hold_q != '0);

    if (state_q == ST_ILLEGAL) begin
      state_d = ST_IDLE;
    end else if (SFA || alarm_hold) begin
      state_d = ST_ALARM;
    end else if (door_hold) begin
      state_d = state_q;
    end else if (SFD) begin
      state_d = ST_FDOOR;
    end else if (SRD) begin
      state_d = ST_RDOOR;
    end else if (|SW) begin
      state_d = ST_WIN;
    end else begin
      state_d = temp_state;
    end

    // Load on door entry, count down while holding, otherwise idle at zero.
    if ((state_d == ST_FDOOR || state_d == ST_RDOOR) && state_d != state_q) begin
      hold_d = HOLD_LOAD;
    end else if (door_hold && state_d == state_q) begin
      hold_d = hold_q - HOLD_W'(1);
    end

    win_id_d = (state_d == ST_WIN) ? win_idx : '0;
  end

  // State, hold counter, window index and actuator registers.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      win_id_q    <= '0;
      fdoor_q     <= 1'b0;
      rdoor_q     <= 1'b0;
      winbuzz_q   <= 1'b0;
      alarmbuzz_q <= 1'b0;
      heater_q    <= 1'b0;
      cooler_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      win_id_q    <= win_id_d;
      fdoor_q     <= (state_d == ST_FDOOR);
      rdoor_q     <= (state_d == ST_RDOOR);
      winbuzz_q   <= (state_d == ST_WIN);
      alarmbuzz_q <= (state_d == ST_ALARM);
      heater_q    <= (state_d == ST_HEAT);
      cooler_q    <= (state_d == ST_COOL);
    end
  end

`ifdef SH_ALARM_LATCH_EN
  // Alarm latch follows entry into and release from ALARM.
  always_ff @(posedge clk) begin
    if (Rst) begin
      latch_q <= 1'b0;
    end else begin
      latch_q <= (state_d == ST_ALARM);
    end
  end
`endif

  assign fdoor     = fdoor_q;
  assign rdoor     = rdoor_q;
  assign winbuzz   = winbuzz_q;
  assign alarmbuzz = alarmbuzz_q;
  assign heater    = heater_q;
  assign cooler    = cooler_q;
  assign win_id    = win_id_q;
  assign display   = state_q;

endmodule

// File: tb/tb_smart_home_ctrl_p.sv
// Directed bench for smart_home_ctrl_p: vector table plus alarm-latch and
// illegal-state sequences. Expected values follow the default parameters.

module tb_smart_home_ctrl_p;
  import smart_home_ctrl_p_pkg::*;

  logic       clk = 1'b0;
  logic       Rst, SFD, SRD, SFA, alarm_ack;
  logic [3:0] SW;
  logic [6:0] ST;
  logic       fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler;
  logic [1:0] win_id;
  logic [2:0] display;

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] A_NONE = 6'b000000;
  localparam logic [5:0] A_F    = 6'b100000;
  localparam logic [5:0] A_R    = 6'b010000;
  localparam logic [5:0] A_W    = 6'b001000;
  localparam logic [5:0] A_A    = 6'b000100;
  localparam logic [5:0] A_H    = 6'b000010;
  localparam logic [5:0] A_C    = 6'b000001;

  typedef struct {
    logic       rst, sfd, srd;
    logic [3:0] sw;
    logic       sfa;
    logic [6:0] st;
    logic       ack;
    logic [2:0] disp;
    logic [5:0] act;
    logic [1:0] wid;
  } vec_t;

  vec_t vecs[$];

  smart_home_ctrl_p dut (
    .clk(clk), .Rst(Rst), .SFD(SFD), .SRD(SRD), .SW(SW), .SFA(SFA), .ST(ST),
    .alarm_ack(alarm_ack), .fdoor(fdoor), .rdoor(rdoor), .winbuzz(winbuzz),
    .alarmbuzz(alarmbuzz), .heater(heater), .cooler(cooler), .win_id(win_id),
    .display(display)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic sfd, input logic srd,
                     input logic [3:0] sw, input logic sfa, input logic [6:0] st,
                     input logic ack, input logic [2:0] disp,
                     input logic [5:0] act, input logic [1:0] wid);
    vec_t v;
    v.rst = rst; v.sfd = sfd; v.srd = srd; v.sw = sw; v.sfa = sfa;
    v.st = st; v.ack = ack; v.disp = disp; v.act = act; v.wid = wid;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic sfd, input logic srd,
                       input logic [3:0] sw, input logic sfa, input logic [6:0] st,
                       input logic ack);
    @(negedge clk);
    Rst = rst; SFD = sfd; SRD = srd; SW = sw; SFA = sfa; ST = st; alarm_ack = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input int idx, input logic [2:0] disp,
                           input logic [5:0] act, input logic [1:0] wid);
    check({name, "_display"}, idx, 8'(display), 8'(disp));
    check({name, "_act"}, idx, 8'({fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler}), 8'(act));
    check({name, "_win_id"}, idx, 8'(win_id), 8'(wid));
  endtask

  logic latched;

  initial begin
    Rst = 1'b1; SFD = 1'b0; SRD = 1'b0; SW = 4'b0; SFA = 1'b0; ST = 7'd60; alarm_ack = 1'b0;
`ifdef SH_ALARM_LATCH_EN
    latched = 1'b1;
`else
    latched = 1'b0;
`endif

    //   rst sfd srd sw       sfa st  ack disp act     wid
    add(1, 0, 0, 4'b1111, 1, 60, 0, 0, A_NONE, 0);  // reset overrides alarm
    add(0, 0, 0, 4'b1111, 1, 60, 0, 3, A_A,    0);  // alarm one edge after release
    add(0, 1, 1, 4'b0100, 0, 20, 0, 1, A_F,    0);  // front door wins
    add(0, 0, 1, 4'b0100, 0, 20, 0, 1, A_F,    0);  // hold 2
    add(0, 0, 1, 4'b0100, 0, 20, 0, 1, A_F,    0);  // hold 1
    add(0, 0, 1, 4'b0100, 0, 20, 0, 1, A_F,    0);  // hold 0
    add(0, 0, 1, 4'b0100, 0, 20, 0, 2, A_R,    0);  // rear door after expiry
    add(0, 0, 1, 4'b0100, 0, 20, 0, 2, A_R,    0);
    add(0, 0, 0, 4'b0100, 0, 20, 0, 2, A_R,    0);  // held despite SRD low
    add(0, 0, 0, 4'b0100, 0, 20, 0, 2, A_R,    0);
    add(0, 0, 0, 4'b0100, 0, 20, 0, 4, A_W,    2);  // window 2
    add(0, 0, 0, 4'b0110, 0, 20, 0, 4, A_W,    1);  // lowest index wins
    add(0, 0, 0, 4'b0000, 0, 20, 0, 5, A_H,    0);  // cold
    add(0, 0, 0, 4'b0000, 0, 60, 0, 0, A_NONE, 0);
    add(0, 1, 0, 4'b0000, 0, 60, 0, 1, A_F,    0);  // one-cycle door pulse
    add(0, 0, 0, 4'b0000, 0, 60, 0, 1, A_F,    0);
    add(0, 0, 0, 4'b0000, 0, 60, 0, 1, A_F,    0);
    add(0, 0, 0, 4'b0000, 0, 60, 0, 1, A_F,    0);
    add(0, 0, 0, 4'b0000, 0, 60, 0, 0, A_NONE, 0);  // exactly four cycles
    add(0, 1, 0, 4'b0000, 0, 60, 0, 1, A_F,    0);
    add(0, 0, 0, 4'b0000, 0, 60, 0, 1, A_F,    0);
    add(0, 0, 0, 4'b0000, 1, 60, 0, 3, A_A,    0);  // fire pre-empts hold
    add(0, 0, 0, 4'b0000, 0, 60, 1, 0, A_NONE, 0);  // cleared + ack
    add(0, 0, 0, 4'b0000, 0, 49, 0, 5, A_H,    0);
    add(0, 0, 0, 4'b0000, 0, 52, 0, 5, A_H,    0);
    add(0, 0, 0, 4'b0000, 0, 53, 0, 0, A_NONE, 0);
    add(0, 0, 0, 4'b0000, 0, 50, 0, 0, A_NONE, 0);
    add(0, 0, 0, 4'b0000, 0, 86, 0, 6, A_C,    0);
    add(0, 0, 0, 4'b0000, 0, 83, 0, 6, A_C,    0);
    add(0, 0, 0, 4'b0000, 0, 82, 0, 0, A_NONE, 0);
    add(0, 0, 0, 4'b0000, 0, 85, 0, 0, A_NONE, 0);  // at threshold: no entry
    add(0, 1, 0, 4'b0000, 0, 60, 0, 1, A_F,    0);
    add(0, 1, 0, 4'b0000, 0, 60, 0, 1, A_F,    0);
    add(0, 1, 0, 4'b0000, 0, 60, 0, 1, A_F,    0);
    add(0, 1, 0, 4'b0000, 0, 60, 0, 1, A_F,    0);
    add(0, 1, 0, 4'b1000, 0, 60, 0, 1, A_F,    0);  // held at zero, door open
    add(0, 0, 0, 4'b1000, 0, 60, 0, 4, A_W,    3);
    add(0, 1, 0, 4'b0000, 0, 60, 0, 1, A_F,    0);
    add(1, 0, 0, 4'b0000, 1, 60, 0, 0, A_NONE, 0);  // reset mid-hold
    add(0, 0, 0, 4'b0000, 0, 60, 0, 0, A_NONE, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].sfd, vecs[i].srd, vecs[i].sw, vecs[i].sfa,
            vecs[i].st, vecs[i].ack);
      check_all("vec", i, vecs[i].disp, vecs[i].act, vecs[i].wid);
    end

    // Alarm latch sequence (expectations depend on the build).
    drive(0, 0, 0, 4'b0000, 1, 60, 0);
    check_all("alm_enter", 0, 3'd3, A_A, 2'd0);
    drive(0, 0, 0, 4'b0000, 0, 60, 0);
    check_all("alm_fall", 1, latched ? 3'd3 : 3'd0, latched ? A_A : A_NONE, 2'd0);
    drive(0, 0, 0, 4'b0000, 1, 60, 1);
    check_all("alm_ack_sfa", 2, 3'd3, A_A, 2'd0);
    drive(0, 0, 0, 4'b0000, 0, 60, 0);
    check_all("alm_noack", 3, latched ? 3'd3 : 3'd0, latched ? A_A : A_NONE, 2'd0);
    drive(0, 0, 0, 4'b0000, 0, 60, 1);
    check_all("alm_release", 4, 3'd0, A_NONE, 2'd0);

    // Illegal state code: forced from HEAT, must go to IDLE regardless of ST.
    drive(0, 0, 0, 4'b0000, 0, 40, 0);
    check_all("ill_pre", 0, 3'd5, A_H, 2'd0);
    @(negedge clk);
    force dut.state_q = ST_ILLEGAL;
    @(posedge clk);
    #1;
    check("ill_act", 1, 8'({fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler}), 8'(A_NONE));
    release dut.state_q;
    drive(0, 0, 0, 4'b0000, 0, 60, 0);
    check_all("ill_post", 2, 3'd0, A_NONE, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
